// File: rtl/array4_tc_pkg.sv
// Shared widths, operand/product types and Baugh-Wooley constant
// for the 4x4 signed array multiplier.
package array4_tc_pkg;

    localparam int OP_W   = 4;
    localparam int PROD_W = 8;

    typedef logic signed [OP_W-1:0]   operand_t;
    typedef logic signed [PROD_W-1:0] product_t;

    // Ones injected at weights 2^4 and 2^7
    localparam logic [PROD_W-1:0] BW_CORR = 8'h90;

endpackage

// File: rtl/array4_tc_if.sv
// Operand/product bundle for array4_tc.
// master drives X, Y and reads Z; slave is the multiplier side.
interface array4_tc_if;
    import array4_tc_pkg::*;

    operand_t X;
    operand_t Y;
    product_t Z;

    modport master (output X, output Y, input Z);
    modport slave  (input X, input Y, output Z);

endinterface

// File: rtl/array4_tc_fa.sv
// 1-bit full-adder cell: s = a^b^cin, cout = majority.
// Used with cin tied low wherever a half adder is needed.
module array4_tc_fa (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/array4_tc.sv
// 4x4 signed Baugh-Wooley array multiplier, registered 8-bit product.
// Ports: Clk, Reset_n (async low), bus (slave: X, Y in; Z out).
// ARRAY4_TC_INREG_EN: register X/Y before the array (latency 2).
module array4_tc
    import array4_tc_pkg::*;
(
    input  logic        Clk,
    input  logic        Reset_n,
    array4_tc_if.slave  bus
);

    operand_t xa;
    operand_t ya;

`ifdef ARRAY4_TC_INREG_EN
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            xa <= '0;
            ya <= '0;
        end else begin
            xa <= bus.X;
            ya <= bus.Y;
        end
    end
`else
    assign xa = bus.X;
    assign ya = bus.Y;
`endif

    // t[j][i]: term for X bit i, Y bit j; sign row/column inverted,
    // corner term kept true
    logic [3:0][3:0] t;

    for (genvar j = 0; j < 4; j++) begin : g_ppj
        for (genvar i = 0; i < 4; i++) begin : g_ppi
            if ((i == 3) && (j == 3)) begin : g_corner
                assign t[j][i] = xa[i] & ya[j];
            end else if ((i == 3) || (j == 3)) begin : g_sign
                assign t[j][i] = ~(xa[i] & ya[j]);
            end else begin : g_plain
                assign t[j][i] = xa[i] & ya[j];
            end
        end
    end

    // fs[r][i]/fc[r][i]: sum/carry of row r cell i, sum weight r+i.
    // Row 0 is the bare first partial-product row.
    logic [3:0][3:0] fs;
    logic [3:0][3:0] fc;

    assign fs[0] = t[0];
    assign fc[0] = '0;

    for (genvar r = 1; r < 4; r++) begin : g_row
        for (genvar i = 0; i < 4; i++) begin : g_cell
            logic bin;
            if (i < 3) begin : g_sum
                assign bin = fs[r-1][i+1];
            end else if (r == 1) begin : g_c4
                // free input at weight 2^4 takes the first correction one
                assign bin = BW_CORR[4];
            end else begin : g_zero
                assign bin = 1'b0;
            end
            array4_tc_fa u_fa (
                .a    (t[r][i]),
                .b    (bin),
                .cin  (fc[r-1][i]),
                .s    (fs[r][i]),
                .cout (fc[r][i])
            );
        end
    end

    // Ripple merge for bits 7:4; top cell absorbs the 2^7 one
    logic [3:0] ms;
    logic [4:0] mc;
    logic       unused_cout;

    assign mc[0]       = 1'b0;
    assign unused_cout = mc[4];

    for (genvar k = 0; k < 4; k++) begin : g_merge
        logic ain;
        if (k < 3) begin : g_sum
            assign ain = fs[3][k+1];
        end else begin : g_c7
            assign ain = BW_CORR[7];
        end
        array4_tc_fa u_fa (
            .a    (ain),
            .b    (fc[3][k]),
            .cin  (mc[k]),
            .s    (ms[k]),
            .cout (mc[k+1])
        );
    end

    product_t p;

    assign p = {ms, fs[3][0], fs[2][0], fs[1][0], fs[0][0]};

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            bus.Z <= '0;
        end else begin
            bus.Z <= p;
        end
    end

endmodule

// File: tb/tb_array4_tc.sv
// Self-checking bench for array4_tc against an integer-multiply model
// with a latency-deep expected-value pipeline.
module tb_array4_tc;
    import array4_tc_pkg::*;

`ifdef ARRAY4_TC_INREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic Clk = 1'b0;
    logic Reset_n = 1'b1;

    array4_tc_if bus ();

    array4_tc dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .bus     (bus)
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;

    product_t pipe [LAT];
    product_t exp_z;
    product_t got [6];

    operand_t dx [7] = '{4'hF, 4'hF, 4'hF, 4'h8, 4'h7, 4'h8, 4'h0};
    operand_t dy [7] = '{4'h5, 4'hF, 4'h8, 4'h8, 4'h7, 4'h7, 4'hB};
    product_t dz [7] = '{8'hFB, 8'h01, 8'h08, 8'h40, 8'h31, 8'hC8, 8'h00};

    operand_t bx [5] = '{4'h3, 4'h6, 4'h9, 4'h0, 4'h0};
    operand_t by [5] = '{4'hE, 4'h2, 4'h9, 4'h0, 4'h0};
    product_t bz [3] = '{8'hFA, 8'h0C, 8'h31};

    function automatic product_t ref_mul(operand_t x, operand_t y);
        int p;
        p = int'(x) * int'(y);
        return p[7:0];
    endfunction

    task automatic chk(string tag, product_t obs, product_t expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic clear_model();
        for (int k = 0; k < LAT; k++) pipe[k] = '0;
    endtask

    // Drive one operand pair, step one edge, check against the model
    task automatic cyc(operand_t x, operand_t y, string tag);
        bus.X = x;
        bus.Y = y;
        @(posedge Clk);
        for (int k = LAT - 1; k > 0; k--) pipe[k] = pipe[k-1];
        pipe[0] = ref_mul(x, y);
        exp_z = pipe[LAT-1];
        #1 chk(tag, bus.Z, exp_z);
        @(negedge Clk);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        bus.X = 4'hF;
        bus.Y = 4'h5;
        Reset_n = 1'b1;
        @(negedge Clk);
        @(negedge Clk);

        // Asynchronous reset: no clock edge between assert and check
        #2 Reset_n = 1'b0;
        #1 chk("reset_async", bus.Z, 8'h00);
        @(negedge Clk);
        chk("reset_hold", bus.Z, 8'h00);
        clear_model();
        Reset_n = 1'b1;

        for (int n = 0; n < LAT; n++) cyc(4'hF, 4'h5, "release");
        chk("release_fb", bus.Z, 8'hFB);

        for (int d = 0; d < 7; d++) begin
            for (int n = 0; n < LAT; n++) cyc(dx[d], dy[d], "directed_model");
            chk("directed_const", bus.Z, dz[d]);
        end

        for (int n = 0; n < 5; n++) begin
            cyc(bx[n], by[n], "b2b_model");
            got[n] = bus.Z;
        end
        for (int k = 0; k < 3; k++) chk("b2b_const", got[LAT-1+k], bz[k]);

        // Mid-stream reset with a pair in flight
        cyc(4'h5, 4'h3, "pre_reset");
        bus.X = 4'h4;
        bus.Y = 4'h4;
        @(posedge Clk);
        #1 Reset_n = 1'b0;
        #1 chk("mid_reset", bus.Z, 8'h00);
        @(negedge Clk);
        chk("mid_reset_hold", bus.Z, 8'h00);
        #1 Reset_n = 1'b1;
        clear_model();
        cyc(4'h2, 4'h3, "post_reset");
        cyc(4'h6, 4'h5, "post_reset");
        cyc(4'h1, 4'h1, "post_reset");

        for (int xi = 0; xi < 16; xi++) begin
            for (int yi = 0; yi < 16; yi++) begin
                cyc(operand_t'(xi), operand_t'(yi), "exhaustive");
            end
        end

        for (int n = 0; n < 200; n++) begin
            cyc(operand_t'($urandom_range(15)),
                operand_t'($urandom_range(15)), "random");
        end

        for (int n = 0; n < LAT; n++) cyc(4'h0, 4'h0, "flush");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
